// File: rtl/dm_access_pkg.sv
// Shared encodings for the data-memory load/store controller.
// Access sizes, FSM states and the request legality check live here.
package dm_access_pkg;

    localparam int ADDR_W_DEF = 10;

    localparam logic [1:0] SZ_B = 2'b00;
    localparam logic [1:0] SZ_H = 2'b01;
    localparam logic [1:0] SZ_W = 2'b10;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        MRG,
        WR,
        DONE
    } state_t;

    // A request is rejected when the size is 11 or the address is not naturally aligned.
    function automatic logic access_bad(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b11) ||
               ((size == SZ_H) && off[0]) ||
               ((size == SZ_W) && (off != 2'b00));
    endfunction

endpackage

// File: rtl/dm_lane_unit.sv
// Byte/halfword lane steering: extracts and extends load data, and merges
// store data into the old memory word for read-modify-write.
module dm_lane_unit
    import dm_access_pkg::*;
(
    input  logic [1:0]  size,
    input  logic        sext,
    input  logic [1:0]  off,
    input  logic [31:0] rword,
    input  logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic [31:0] merge_data
);

    function automatic logic [31:0] lane_extract(input logic [1:0] sz, input logic sx,
                                                 input logic [1:0] lane, input logic [31:0] word);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] res;
        b   = word[{lane, 3'b000} +: 8];
        h   = lane[1] ? word[31:16] : word[15:0];
        res = word;
        case (sz)
            SZ_B:    res = sx ? {{24{b[7]}}, b} : {24'h000000, b};
            SZ_H:    res = sx ? {{16{h[15]}}, h} : {16'h0000, h};
            default: res = word;
        endcase
        return res;
    endfunction

    function automatic logic [31:0] lane_merge(input logic [1:0] sz, input logic [1:0] lane,
                                               input logic [31:0] old, input logic [31:0] wd);
        logic [31:0] res;
        res = old;
        case (sz)
            SZ_B: res[{lane, 3'b000} +: 8] = wd[7:0];
            SZ_H: begin
                if (lane[1]) res[31:16] = wd[15:0];
                else         res[15:0]  = wd[15:0];
            end
            default: res = wd;
        endcase
        return res;
    endfunction

    assign load_data  = lane_extract(size, sext, off, rword);
    assign merge_data = lane_merge(size, off, rword, wdata);

endmodule

// File: rtl/dm_access_ctrl.sv
// Load/store controller in front of a full-word, registered-read data memory.
// Sub-word stores are done as read-modify-write; loads return extended lane data.
module dm_access_ctrl
    import dm_access_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req,
    input  logic              we,
    input  logic [1:0]        size,
    input  logic              sext,
    input  logic [31:0]       addr,
    input  logic [31:0]       wdata,
    output logic              busy,
    output logic              done,
    output logic              err,
    output logic [31:0]       rdata,
    output logic [ADDR_W-1:0] dm_addr,
    output logic [31:0]       dm_din,
    output logic              dm_we,
    input  logic [31:0]       dm_dout
);

    state_t             state_reg, state_next;
    logic [ADDR_W-1:0]  waddr_reg;
    logic [1:0]         off_reg;
    logic [1:0]         size_reg;
    logic               we_reg;
    logic               sext_reg;
    logic               err_reg;
    logic [31:0]        wdata_reg;
    logic [31:0]        rdata_reg;
    logic [31:0]        din_reg;
    logic [31:0]        lane_load;
    logic [31:0]        lane_merge;
    logic               bad_req;
    logic               accept;

    // Address bits above the memory window are dropped, so accesses wrap modulo 4 KB.
    logic unused_addr_bits;
    assign unused_addr_bits = ^addr[31:ADDR_W+2];

    assign bad_req = access_bad(size, addr[1:0]);
    assign accept  = (state_reg == IDLE) && req;

    dm_lane_unit u_lane (
        .size       (size_reg),
        .sext       (sext_reg),
        .off        (off_reg),
        .rword      (dm_dout),
        .wdata      (wdata_reg),
        .load_data  (lane_load),
        .merge_data (lane_merge)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_reg <= IDLE;
        else        state_reg <= state_next;
    end

    always_comb begin
        state_next = state_reg;
        done       = 1'b0;
        err        = 1'b0;
        dm_we      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (req) begin
                    if (bad_req)                     state_next = DONE;
                    else if (we && (size == SZ_W))   state_next = WR;
                    else                             state_next = RD;
                end
            end
            RD:  state_next = MRG;
            MRG: state_next = we_reg ? WR : DONE;
            WR: begin
                dm_we      = 1'b1;
                state_next = DONE;
            end
            DONE: begin
                done       = 1'b1;
                err        = err_reg;
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waddr_reg <= '0;
            off_reg   <= 2'b00;
            size_reg  <= 2'b00;
            we_reg    <= 1'b0;
            sext_reg  <= 1'b0;
            err_reg   <= 1'b0;
            wdata_reg <= 32'h0;
            rdata_reg <= 32'h0;
            din_reg   <= 32'h0;
        end else begin
            if (accept) begin
                waddr_reg <= addr[ADDR_W+1:2];
                off_reg   <= addr[1:0];
                size_reg  <= size;
                we_reg    <= we;
                sext_reg  <= sext;
                err_reg   <= bad_req;
                wdata_reg <= wdata;
                // Word stores skip the read, so the write word is staged right away.
                if (we && (size == SZ_W) && !bad_req) din_reg <= wdata;
            end
            if (state_reg == MRG) begin
                if (we_reg) din_reg   <= lane_merge;
                else        rdata_reg <= lane_load;
            end
        end
    end

    assign busy    = (state_reg != IDLE);
    assign rdata   = rdata_reg;
    assign dm_addr = waddr_reg;
    assign dm_din  = din_reg;

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Directed bench for dm_access_ctrl with a registered-read memory, a
// transaction-level reference model and a per-cycle compare thread.
module tb_dm_access_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req = 1'b0;
    logic        we = 1'b0;
    logic [1:0]  size = 2'b00;
    logic        sext = 1'b0;
    logic [31:0] addr = 32'h0;
    logic [31:0] wdata = 32'h0;
    logic        busy, done, err, dm_we;
    logic [31:0] rdata, dm_din;
    logic [9:0]  dm_addr;
    logic [31:0] dm_dout = 32'h0;

    int vectors = 0;
    int miscompares = 0;

    dm_access_ctrl #(.ADDR_W(10)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .we(we), .size(size), .sext(sext),
        .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err),
        .rdata(rdata), .dm_addr(dm_addr), .dm_din(dm_din), .dm_we(dm_we),
        .dm_dout(dm_dout)
    );

    always #5 clk = ~clk;

    // Memory the DUT drives: full-word write, registered read.
    logic [31:0] mem [0:1023];
    always @(posedge clk) begin
        if (dm_we) mem[dm_addr] <= dm_din;
        dm_dout <= mem[dm_addr];
    end

    // ---------------- reference model ----------------
    function automatic logic [31:0] size_mask(input logic [1:0] sz);
        if (sz == 2'd0) return 32'h0000_00FF;
        if (sz == 2'd1) return 32'h0000_FFFF;
        return 32'hFFFF_FFFF;
    endfunction

    function automatic logic is_illegal(input logic [1:0] sz, input logic [1:0] off);
        int nbytes;
        if (sz == 2'd3) return 1'b1;
        nbytes = 1 << sz;
        return (int'(off) % nbytes) != 0;
    endfunction

    function automatic int latency_of(input logic w, input logic [1:0] sz, input logic [1:0] off);
        if (is_illegal(sz, off)) return 1;
        if (w) return (sz == 2'd2) ? 2 : 4;
        return 3;
    endfunction

    function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                               input logic sx, input logic [1:0] off);
        logic [31:0] m, v;
        m = size_mask(sz);
        v = (word >> (int'(off) * 8)) & m;
        if (sx && (sz != 2'd2) && ((v & ~(m >> 1)) != 0)) v = v | ~m;
        return v;
    endfunction

    function automatic logic [31:0] model_merge(input logic [31:0] old, input logic [31:0] wd,
                                                input logic [1:0] sz, input logic [1:0] off);
        logic [31:0] m;
        m = size_mask(sz) << (int'(off) * 8);
        return (old & ~m) | ((wd << (int'(off) * 8)) & m);
    endfunction

    int          cnt = 0;      // cycles since accept, 0 = idle
    int          lat = 1;
    logic        m_we = 1'b0, m_err = 1'b0, m_sx = 1'b0;
    logic [1:0]  m_sz = 2'b00, m_off = 2'b00;
    logic [9:0]  m_idx = 10'h0;
    logic [31:0] m_din = 32'h0;
    logic [31:0] exp_rdata = 32'h0;
    logic [31:0] gold [0:1023];

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt       <= 0;
            exp_rdata <= 32'h0;
        end else if (cnt == 0) begin
            if (req) begin
                cnt   <= 1;
                lat   <= latency_of(we, size, addr[1:0]);
                m_we  <= we;
                m_err <= is_illegal(size, addr[1:0]);
                m_sz  <= size;
                m_sx  <= sext;
                m_off <= addr[1:0];
                m_idx <= addr[11:2];
                m_din <= (size == 2'd2) ? wdata : model_merge(gold[addr[11:2]], wdata, size, addr[1:0]);
            end
        end else begin
            cnt <= (cnt == lat) ? 0 : cnt + 1;
            if (!m_err && (cnt == lat - 1)) begin
                if (m_we) gold[m_idx] <= m_din;
                else      exp_rdata <= model_load(gold[m_idx], m_sz, m_sx, m_off);
            end
        end
    end

    // ---------------- checking ----------------
    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %h expected %h", nm, $time, act, exp);
        end
    endtask

    task automatic compare_cycle();
        logic exp_done, exp_wr;
        exp_done = (cnt != 0) && (cnt == lat);
        exp_wr   = (cnt != 0) && m_we && !m_err && (cnt == lat - 1);
        chk("busy",  {31'b0, busy},  {31'b0, cnt != 0});
        chk("done",  {31'b0, done},  {31'b0, exp_done});
        chk("err",   {31'b0, err},   {31'b0, exp_done && m_err});
        chk("dm_we", {31'b0, dm_we}, {31'b0, exp_wr});
        chk("rdata", rdata, exp_rdata);
        if (exp_wr) begin
            chk("dm_addr", {22'b0, dm_addr}, {22'b0, m_idx});
            chk("dm_din", dm_din, m_din);
        end
        if (!rst_n) begin
            chk("rst_dm_din", dm_din, 32'h0);
            chk("rst_dm_addr", {22'b0, dm_addr}, 32'h0);
        end
    endtask

    // One access: req for a single cycle, inputs scrambled after accept,
    // optional busy-time req poke, then latency/err/rdata/dm_din literals.
    task automatic acc(input string nm, input logic w, input logic [1:0] sz, input logic sx,
                       input logic [31:0] a, input logic [31:0] d, input int exp_lat,
                       input logic exp_err, input logic chk_rd, input logic [31:0] exp_rd,
                       input logic chk_din, input logic [31:0] exp_din, input logic poke);
        int got;
        logic [31:0] seen_din;
        @(posedge clk); #1;
        we = w; size = sz; sext = sx; addr = a; wdata = d; req = 1'b1;
        @(posedge clk); #1;
        req = 1'b0; wdata = ~d; addr = a ^ 32'h0000_0FFF; sext = ~sx; size = ~sz; we = ~w;
        got = 0;
        seen_din = 32'hxxxx_xxxx;
        for (int c = 1; c <= 20; c++) begin
            @(negedge clk);
            if (poke && c == 2) begin
                req = 1'b1; we = 1'b1; size = 2'd2; addr = 32'h010; wdata = 32'hCAFE_F00D;
            end
            if (poke && c == 3) req = 1'b0;
            if (dm_we) seen_din = dm_din;
            if (done) begin
                got = c;
                break;
            end
        end
        $display("acc %s we=%0d size=%0d sext=%0d addr=%h wdata=%h latency=%0d err=%0d rdata=%h",
                 nm, w, sz, sx, a, d, got, err, rdata);
        chk({nm, "_latency"}, got, exp_lat);
        chk({nm, "_err"}, {31'b0, err}, {31'b0, exp_err});
        if (chk_rd)  chk({nm, "_rdata"}, rdata, exp_rd);
        if (chk_din) chk({nm, "_wrdata"}, seen_din, exp_din);
    endtask

    initial begin
        fork
            forever begin
                @(negedge clk);
                compare_cycle();
            end
            begin
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                @(negedge clk);
                chk("reset_busy", {31'b0, busy}, 32'h0);
                chk("reset_rdata", rdata, 32'h0);
                chk("reset_dm_we", {31'b0, dm_we}, 32'h0);

                acc("st_w",      1, 2'd2, 0, 32'h010, 32'hDEAD_BEEF, 2, 0, 0, 0, 1, 32'hDEAD_BEEF, 0);
                acc("ld_w",      0, 2'd2, 0, 32'h010, 32'h0, 3, 0, 1, 32'hDEAD_BEEF, 0, 0, 0);
                acc("st_w2",     1, 2'd2, 0, 32'h010, 32'h1122_3344, 2, 0, 0, 0, 1, 32'h1122_3344, 0);
                acc("st_b",      1, 2'd0, 0, 32'h012, 32'hAAAA_AA5A, 4, 0, 0, 0, 1, 32'h115A_3344, 0);
                acc("ld_w_rmw",  0, 2'd2, 0, 32'h010, 32'h0, 3, 0, 1, 32'h115A_3344, 0, 0, 0);
                acc("st_w3",     1, 2'd2, 0, 32'h010, 32'h80FF_7F01, 2, 0, 0, 0, 0, 0, 0);
                acc("ld_b_sx",   0, 2'd0, 1, 32'h013, 32'h0, 3, 0, 1, 32'hFFFF_FF80, 0, 0, 0);
                acc("ld_b_zx",   0, 2'd0, 0, 32'h013, 32'h0, 3, 0, 1, 32'h0000_0080, 0, 0, 0);
                acc("st_w4",     1, 2'd2, 0, 32'h000, 32'h8001_1234, 2, 0, 0, 0, 0, 0, 0);
                acc("ld_h_sx",   0, 2'd1, 1, 32'h002, 32'h0, 3, 0, 1, 32'hFFFF_8001, 0, 0, 0);
                acc("ld_h_mis",  0, 2'd1, 1, 32'h001, 32'h0, 1, 1, 1, 32'hFFFF_8001, 0, 0, 0);
                acc("ld_sz11",   0, 2'd3, 0, 32'h000, 32'h0, 1, 1, 1, 32'hFFFF_8001, 0, 0, 0);
                acc("st_w_mis",  1, 2'd2, 0, 32'h012, 32'h5555_5555, 1, 1, 0, 0, 0, 0, 0);
                acc("ld_unchg",  0, 2'd2, 0, 32'h010, 32'h0, 3, 0, 1, 32'h80FF_7F01, 0, 0, 0);
                acc("st_h_hi",   1, 2'd1, 0, 32'h002, 32'h1234_BEEF, 4, 0, 0, 0, 1, 32'hBEEF_1234, 0);
                acc("ld_h_zx",   0, 2'd1, 0, 32'h002, 32'h0, 3, 0, 1, 32'h0000_BEEF, 0, 0, 0);
                acc("ld_b1_sx",  0, 2'd0, 1, 32'h001, 32'h0, 3, 0, 1, 32'h0000_0012, 0, 0, 0);
                acc("ld_b3_sx",  0, 2'd0, 1, 32'h003, 32'h0, 3, 0, 1, 32'hFFFF_FFBE, 0, 0, 0);
                acc("st_wrap",   1, 2'd2, 0, 32'hFFFF_F020, 32'h0BAD_F00D, 2, 0, 0, 0, 1, 32'h0BAD_F00D, 0);
                acc("ld_wrap",   0, 2'd2, 0, 32'h0000_1020, 32'h0, 3, 0, 1, 32'h0BAD_F00D, 0, 0, 0);
                acc("st_b_poke", 1, 2'd0, 0, 32'h011, 32'h0000_0099, 4, 0, 0, 0, 1, 32'h80FF_9901, 1);
                acc("ld_poke",   0, 2'd2, 0, 32'h010, 32'h0, 3, 0, 1, 32'h80FF_9901, 0, 0, 0);

                // req held high: second accept lands in the IDLE cycle after DONE
                begin
                    int t1, gap;
                    @(posedge clk); #1;
                    we = 1'b0; size = 2'd2; sext = 1'b0; addr = 32'h000; req = 1'b1;
                    t1 = 0;
                    gap = 0;
                    for (int c = 1; c <= 20; c++) begin
                        @(negedge clk);
                        if (done) begin t1 = c; break; end
                    end
                    for (int c = 1; c <= 20; c++) begin
                        @(negedge clk);
                        if (done) begin gap = c; break; end
                    end
                    req = 1'b0;
                    $display("acc held_req first_done=%0d gap=%0d rdata=%h", t1, gap, rdata);
                    chk("held_first", t1, 4);
                    chk("held_gap", gap, 4);
                    chk("held_rdata", rdata, 32'hBEEF_1234);
                end

                // reset asserted mid-WR of a byte store
                @(posedge clk); #1;
                we = 1'b1; size = 2'd0; sext = 1'b0; addr = 32'h010; wdata = 32'h0000_0044; req = 1'b1;
                @(posedge clk); #1;
                req = 1'b0;
                @(posedge clk);
                @(posedge clk); #2;
                chk("rst_pre_we", {31'b0, dm_we}, 32'h1);
                rst_n = 1'b0;
                #1;
                chk("rst_we_drop", {31'b0, dm_we}, 32'h0);
                chk("rst_busy", {31'b0, busy}, 32'h0);
                chk("rst_din", dm_din, 32'h0);
                chk("rst_rdata", rdata, 32'h0);
                $display("acc reset_in_wr dm_we=%0d busy=%0d", dm_we, busy);
                repeat (2) @(negedge clk);
                rst_n = 1'b1;
                acc("ld_after_rst", 0, 2'd2, 0, 32'h010, 32'h0, 3, 0, 1, 32'h80FF_9901, 0, 0, 0);
                repeat (3) @(negedge clk);
            end
        join_any
        disable fork;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
